issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameters (in package), one per line: name, default, meaning.
  RS_SIZE  16  reservation-station entries scanned; RS_IDX_W = clog2(RS_SIZE)
  MULT_LAT  4  cycles the non-pipelined multiplier stays busy after issue
  FU_NUM  5  functional-unit classes; FU_SEL encoding FU_ALU=0, FU_LOAD=1, FU_STORE=2, FU_MULT=3, FU_BRANCH=4
REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-low.
  clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset
  entry_ready  in  RS_SIZE  entry i valid with both operand tags ready
  entry_fu  in  RS_SIZE x FU_SEL  FU class of entry i
  issue_stall  in  1  downstream issue register full; no issue this cycle
  mem_done  in  1  outstanding load/store completed this cycle
  squash  in  1  branch-mispredict flush
  issue_enable  out  1  one entry granted this cycle
  issue_index  out  RS_IDX_W  granted entry index
  issue_fu  out  FU_SEL  class of granted entry
  free  out  FU_NUM  per-class availability, bit index = FU_SEL value

Function
REQ-003 free[FU_ALU] and free[FU_BRANCH] SHALL be constant 1 (pipelined single-cycle units).
REQ-004 free[FU_MULT] SHALL be 1 iff registered mult_cnt == 0.
REQ-005 free[FU_LOAD] and free[FU_STORE] SHALL both equal ~mem_busy (one shared memory port).
REQ-006 Candidate i SHALL be entry_ready[i] && free[entry_fu[i]]; grant SHALL be combinational in the same cycle, at most one per cycle.
REQ-007 issue_enable SHALL be 1 iff some candidate exists, issue_stall == 0 and squash == 0; when 0, issue_index and issue_fu SHALL be 0.
REQ-008 Grant of an FU_MULT entry SHALL load mult_cnt <= MULT_LAT at the clock edge; otherwise a nonzero mult_cnt SHALL decrement by 1 per cycle, including during issue_stall.
REQ-009 Grant of FU_LOAD/FU_STORE SHALL set mem_busy at the edge; mem_done with mem_busy == 1 SHALL clear it; mem_done with mem_busy == 0 SHALL be ignored.
REQ-010 Issue of a memory op in the same cycle mem_done clears the previous op is impossible (free low); mem_busy SHALL clear and new memory issue SHALL be allowed from the next cycle.
REQ-011 squash SHALL clear mult_cnt to 0 at the edge and block issue that cycle; mem_busy SHALL be held (memory transactions are not cancelled).
REQ-012 squash and issue_stall together SHALL behave as squash.

Reset
REQ-013 reset low SHALL asynchronously clear mult_cnt, mem_busy and the priority pointer to 0; while reset is low issue_enable SHALL be 0 and free SHALL read 5'b11111.
REQ-014 Reset asserted mid-multiply or mid-memory-op SHALL abandon the operation; mem_done after reset release SHALL be ignored.

Configuration
REQ-015 With ISSUE_RR_EN defined, selection SHALL use a rotating pointer starting at 0; after each grant, pointer <= (issue_index + 1) mod RS_SIZE, wrapping 15 -> 0; lowest index at or above pointer wins, wrapping.
REQ-016 Without ISSUE_RR_EN, selection SHALL be fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-017 RS_SIZE, MULT_LAT, FU_NUM and the FU_SEL enum SHALL live in the shared sys_defs package.
REQ-018 Selection logic SHALL be a sub-module rr_picker (request vector plus base pointer in, one-hot grant and index out); without ISSUE_RR_EN its base is tied to 0.

Verification
REQ-019 Bench SHALL cover:
  entry_ready=16'h0006, entries 1,2 FU_ALU, no stall -> issue_index=1 cycle 1; with ISSUE_RR_EN issue_index=2 next cycle.
  entry 3 FU_MULT granted at cycle t -> free[FU_MULT]=0 cycles t+1..t+4, =1 at t+5; second MULT entry issues at t+5.
  entry 0 FU_LOAD granted -> free[1]=free[2]=0 until cycle after mem_done; STORE entry 5 issues then.
  squash one cycle after MULT grant -> no issue that cycle, free[FU_MULT]=1 next cycle, mem_busy unchanged.
  issue_stall=1 with ready entries -> issue_enable=0, mult_cnt still counts down 4 -> 3.
  reset low mid-LOAD -> free=5'b11111 immediately; stray mem_done after release ignored.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared scheduler definitions: RS geometry, multiplier latency, FU classes.
package sys_defs;
   localparam int RS_SIZE  = 16;
   localparam int RS_IDX_W = $clog2(RS_SIZE);
   localparam int MULT_LAT = 4;
   localparam int FU_NUM   = 5;
   localparam int FU_W     = 3;
   localparam int MCNT_W   = $clog2(MULT_LAT + 1);

   typedef enum logic [FU_W-1:0] {
      FU_ALU    = 3'd0,
      FU_LOAD   = 3'd1,
      FU_STORE  = 3'd2,
      FU_MULT   = 3'd3,
      FU_BRANCH = 3'd4
   } fu_sel_e;

   function automatic logic [RS_IDX_W-1:0] wrap_inc(input logic [RS_IDX_W-1:0] i);
      return (i == RS_IDX_W'(RS_SIZE - 1)) ? '0 : i + 1'b1;
   endfunction
endpackage

// File: rtl/issue_scheduler_rr_picker.sv
// rr_picker: first request at or above base (wrapping) wins; one-hot grant plus index.
module rr_picker #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] base,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);
   int j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(base) + k) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = W'(j);
         end
      end
   end
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: picks one ready RS entry per cycle whose FU class is free.
// Optional ISSUE_RR_EN macro switches fixed priority to a rotating pointer.
module issue_scheduler
   import sys_defs::*;
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic [RS_SIZE-1:0]            entry_ready,
   input  logic [RS_SIZE-1:0][FU_W-1:0]  entry_fu,
   input  logic                          issue_stall,
   input  logic                          mem_done,
   input  logic                          squash,
   output logic                          issue_enable,
   output logic [RS_IDX_W-1:0]           issue_index,
   output logic [FU_W-1:0]               issue_fu,
   output logic [FU_NUM-1:0]             free
);
   logic [MCNT_W-1:0]   mult_cnt;
   logic                mem_busy;
   logic [7:0]          free_ext;
   logic [RS_SIZE-1:0]  cand;
   logic [RS_SIZE-1:0]  gnt;
   logic [RS_IDX_W-1:0] pick_idx;
   logic                pick_any;
   logic [RS_IDX_W-1:0] base;
   logic [FU_W-1:0]     pick_fu;
   logic                mult_iss;
   logic                mem_iss;

   assign free = {1'b1, (mult_cnt == '0), ~mem_busy, ~mem_busy, 1'b1};
   // Zero-extended so an out-of-range class code simply reads as not free.
   assign free_ext = {{(8-FU_NUM){1'b0}}, free};

   for (genvar i = 0; i < RS_SIZE; i++) begin : g_cand
      assign cand[i] = entry_ready[i] & free_ext[entry_fu[i]];
   end

   rr_picker #(.N(RS_SIZE), .W(RS_IDX_W)) u_pick (
      .req  (cand),
      .base (base),
      .gnt  (gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_comb begin
      pick_fu = '0;
      for (int i = 0; i < RS_SIZE; i++)
         pick_fu = pick_fu | (entry_fu[i] & {FU_W{gnt[i]}});
   end

   assign issue_enable = reset & pick_any & ~issue_stall & ~squash;
   assign issue_index  = issue_enable ? pick_idx : '0;
   assign issue_fu     = issue_enable ? pick_fu  : '0;
   assign mult_iss     = issue_enable && (issue_fu == FU_MULT);
   assign mem_iss      = issue_enable && (issue_fu == FU_LOAD || issue_fu == FU_STORE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mult_cnt <= '0;
      end else if (squash) begin
         mult_cnt <= '0;
      end else if (mult_iss) begin
         mult_cnt <= MCNT_W'(MULT_LAT);
      end else if (mult_cnt != '0) begin
         mult_cnt <= mult_cnt - 1'b1;
      end
   end

   // A memory issue can only happen while idle, so set and clear never collide.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_busy <= 1'b0;
      end else if (mem_iss) begin
         mem_busy <= 1'b1;
      end else if (mem_done && mem_busy) begin
         mem_busy <= 1'b0;
      end
   end

`ifdef ISSUE_RR_EN
   logic [RS_IDX_W-1:0] ptr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (issue_enable) begin
         ptr <= wrap_inc(issue_index);
      end
   end

   assign base = ptr;
`else
   assign base = '0;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: priority, MULT busy window, memory port, squash, stall, reset.
module tb_issue_scheduler;
   import sys_defs::*;

   logic                         clock = 1'b0;
   logic                         reset = 1'b1;
   logic [RS_SIZE-1:0]           entry_ready = '0;
   logic [RS_SIZE-1:0][FU_W-1:0] entry_fu = '0;
   logic                         issue_stall = 1'b0;
   logic                         mem_done = 1'b0;
   logic                         squash = 1'b0;
   logic                         issue_enable;
   logic [RS_IDX_W-1:0]          issue_index;
   logic [FU_W-1:0]              issue_fu;
   logic [FU_NUM-1:0]            free;

   int n_cmp = 0;
   int n_bad = 0;

   issue_scheduler dut (
      .clock        (clock),
      .reset        (reset),
      .entry_ready  (entry_ready),
      .entry_fu     (entry_fu),
      .issue_stall  (issue_stall),
      .mem_done     (mem_done),
      .squash       (squash),
      .issue_enable (issue_enable),
      .issue_index  (issue_index),
      .issue_fu     (issue_fu),
      .free         (free)
   );

   always #5 clock = ~clock;

   function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      // reset: outputs idle, all units free, even with a ready entry presented
      #2 reset = 1'b0;
      entry_ready = 16'h0001;
      settle();
      chk("rst_free", 32'(free), 32'h1F);
      chk("rst_en", 32'(issue_enable), 32'd0);
      chk("rst_idx", 32'(issue_index), 32'd0);
      tick();
      reset = 1'b1;
      entry_ready = '0;
      tick();

      // two ALU entries: lowest wins first; rotation moves to entry 2 next
      entry_fu = '0;
      entry_ready = 16'h0006;
      settle();
      chk("alu_en", 32'(issue_enable), 32'd1);
      chk("alu_idx1", 32'(issue_index), 32'd1);
      chk("alu_fu", 32'(issue_fu), 32'(FU_ALU));
      tick();
      settle();
`ifdef ISSUE_RR_EN
      chk("alu_idx2_rr", 32'(issue_index), 32'd2);
`else
      chk("alu_idx2_fix", 32'(issue_index), 32'd1);
`endif
      tick();

      // MULT entry 3 at t: busy t+1..t+4, entry 4 MULT issues at t+5
      entry_fu[3] = FU_MULT;
      entry_fu[4] = FU_MULT;
      entry_ready = 16'h0008;
      settle();
      chk("mul_idx", 32'(issue_index), 32'd3);
      chk("mul_fu", 32'(issue_fu), 32'(FU_MULT));
      tick();
      entry_ready = 16'h0010;
      for (int c = 1; c <= 4; c++) begin
         settle();
         chk($sformatf("mul_busy_t%0d", c), 32'(free[FU_MULT]), 32'd0);
         chk($sformatf("mul_noiss_t%0d", c), 32'(issue_enable), 32'd0);
         tick();
      end
      settle();
      chk("mul_free_t5", 32'(free[FU_MULT]), 32'd1);
      chk("mul2_idx", 32'(issue_index), 32'd4);
      tick();

      // stall from s+1: nothing issues, but the MULT window still expires at s+5
      entry_ready = 16'h0012;
      issue_stall = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         settle();
         chk($sformatf("stl_en_s%0d", c), 32'(issue_enable), 32'd0);
         chk($sformatf("stl_busy_s%0d", c), 32'(free[FU_MULT]), 32'd0);
         tick();
      end
      settle();
      chk("stl_free_s5", 32'(free[FU_MULT]), 32'd1);
      chk("stl_en_s5", 32'(issue_enable), 32'd0);
      issue_stall = 1'b0;
      entry_ready = '0;
      tick();

      // LOAD entry 0 holds the memory port
      entry_fu[0] = FU_LOAD;
      entry_fu[5] = FU_STORE;
      entry_ready = 16'h0001;
      settle();
      chk("ld_idx", 32'(issue_index), 32'd0);
      chk("ld_fu", 32'(issue_fu), 32'(FU_LOAD));
      tick();
      // STORE 5 blocked by busy port, MULT 3 issues
      entry_ready = 16'h0028;
      settle();
      chk("ld_busy", 32'(free[2:1]), 32'd0);
      chk("mul3_idx", 32'(issue_index), 32'd3);
      tick();
      // squash (with stall) one cycle after MULT grant
      squash = 1'b1;
      issue_stall = 1'b1;
      entry_ready = 16'h0022;
      settle();
      chk("sq_en", 32'(issue_enable), 32'd0);
      chk("sq_idx", 32'(issue_index), 32'd0);
      chk("sq_fu", 32'(issue_fu), 32'd0);
      tick();
      squash = 1'b0;
      issue_stall = 1'b0;
      entry_ready = 16'h0020;
      mem_done = 1'b1;
      settle();
      chk("sq_mulfree", 32'(free[FU_MULT]), 32'd1);
      chk("sq_memheld", 32'(free[2:1]), 32'd0);
      chk("done_noiss", 32'(issue_enable), 32'd0);
      tick();
      mem_done = 1'b0;
      settle();
      chk("done_free", 32'(free[2:1]), 32'h3);
      chk("st_idx", 32'(issue_index), 32'd5);
      chk("st_fu", 32'(issue_fu), 32'(FU_STORE));
      tick();
      entry_ready = '0;
      settle();
      chk("st_busy", 32'(free[2:1]), 32'd0);

      // asynchronous reset mid-store, then a stray mem_done
      #1 reset = 1'b0;
      #1;
      chk("arst_free", 32'(free), 32'h1F);
      chk("arst_en", 32'(issue_enable), 32'd0);
      tick();
      reset = 1'b1;
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      entry_ready = 16'h0001;
      settle();
      chk("post_free", 32'(free), 32'h1F);
      chk("post_ld_idx", 32'(issue_index), 32'd0);
      tick();
      entry_ready = '0;
      settle();
      chk("post_ld_busy", 32'(free[1]), 32'd0);
      tick();
      settle();
      chk("post_ld_hold", 32'(free[2]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
